// File: rtl/bcd_pkg.sv
// Shared BCD conversion constants and the converter state encoding,
// used by both the BCD-to-binary and binary-to-BCD converters.
package bcd_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] ADJUST_THRESH = 4'd8;
  localparam logic [3:0] ADJUST_SUB    = 4'd3;

endpackage

// File: rtl/bcd_digit_unadjust.sv
// One reverse-double-dabble correction: a shifted BCD nibble that reads 8 or
// more has absorbed a carry from the digit above, so 3 is taken back off.
module bcd_digit_unadjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= ADJUST_THRESH) ? (digit - ADJUST_SUB) : digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter: one reverse-double-dabble step
// per clock, 4*DIGITS steps per conversion, with overflow and invalid flags.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int WIDTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] bcd,
  output logic [WIDTH-1:0]    number,
  output logic                ready,
  output logic                overflow,
  output logic                invalid
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BW + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(BW - 1);

  state_t         state;
  state_t         state_d;
  logic [BW-1:0]  bcd_q;
  logic [BW-1:0]  acc_q;
  logic [BW-1:0]  bcd_shift;
  logic [BW-1:0]  bcd_step;
  logic [BW-1:0]  acc_step;
  logic [CW-1:0]  cnt_q;
  logic           inv_q;
  logic           bad_digit;
  logic           start;
  logic           step;
  logic           done;
  logic [WIDTH-1:0] acc_fit;
  logic           acc_ovf;

  // Handshake: ready=1 means the result outputs are valid and a load on this
  // edge is accepted; ready=0 means busy, load is ignored and bcd unsampled.
  assign ready = (state == IDLE);

  // {bcd_q, acc_q} shifted right by one as a single 2*BW-bit register.
  assign bcd_shift = {1'b0, bcd_q[BW-1:1]};
  assign acc_step  = {bcd_q[0], acc_q[BW-1:1]};

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_digit_unadjust u_unadjust (
      .digit    (bcd_shift[4*d +: 4]),
      .adjusted (bcd_step[4*d +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] > BCD_DIGIT_MAX) bad_digit = 1'b1;
    end
  end

  if (WIDTH > BW) begin : g_wide
    assign acc_fit = {{(WIDTH - BW){1'b0}}, acc_step};
    assign acc_ovf = 1'b0;
  end else if (WIDTH == BW) begin : g_equal
    assign acc_fit = acc_step;
    assign acc_ovf = 1'b0;
  end else begin : g_narrow
    assign acc_fit = acc_step[WIDTH-1:0];
    assign acc_ovf = |acc_step[BW-1:WIDTH];
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          start   = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        step = 1'b1;
        if (cnt_q == LAST_STEP) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      inv_q    <= 1'b0;
      number   <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else if (start) begin
      bcd_q <= bcd;
      acc_q <= '0;
      cnt_q <= '0;
      inv_q <= bad_digit;
    end else if (step) begin
      bcd_q <= bcd_step;
      acc_q <= acc_step;
      cnt_q <= done ? '0 : cnt_q + CW'(1);
      if (done) begin
        invalid <= inv_q;
        if (inv_q) begin
          number   <= '0;
          overflow <= 1'b0;
        end else if (acc_ovf) begin
          number   <= '1;
          overflow <= 1'b1;
        end else begin
          number   <= acc_fit;
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameter DIGITS, default 5: number of packed BCD digits on the input.
REQ-002 Parameter WIDTH, default 16: binary result width.
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 load  input  1: start-conversion strobe, sampled on clk.
REQ-006 bcd  input  4*DIGITS: packed BCD, digit 0 in bits [3:0], most-significant digit in top nibble.
REQ-007 number  output  WIDTH: binary result, valid while ready=1.
REQ-008 ready  output  1: high = idle with result valid / new load accepted.
REQ-009 overflow  output  1: last result exceeded 2^WIDTH-1, valid while ready=1.
REQ-010 invalid  output  1: last loaded bcd contained a nibble > 9, valid while ready=1.

Function
REQ-011 The block SHALL have states IDLE and CONVERT; IDLE drives ready=1, CONVERT drives ready=0.
REQ-012 load=1 in IDLE SHALL capture bcd into a 4*DIGITS shift register, clear a 4*DIGITS-bit binary accumulator and iteration counter, and enter CONVERT on the same edge.
REQ-013 load in CONVERT SHALL be ignored; bcd is not re-sampled.
REQ-014 Each CONVERT cycle SHALL perform one reverse-double-dabble step: shift {bcd_reg, acc} right 1 bit, then subtract 3 from every BCD nibble whose post-shift value is >= 8.
REQ-015 After exactly 4*DIGITS steps the block SHALL return to IDLE, updating number/overflow/invalid and raising ready on that final step's edge; load-to-ready latency is 4*DIGITS cycles (20 at defaults).
REQ-016 invalid SHALL be computed from the captured bcd at load (any nibble > 9) and held through conversion.
REQ-017 overflow SHALL be 1 when any acc bit at index >= WIDTH is set at completion.
REQ-018 Result priority: invalid -> number=0, overflow=0; else overflow -> number=all ones; else number=acc[WIDTH-1:0].
REQ-019 If WIDTH >= 4*DIGITS, overflow SHALL be constant 0 and number zero-extended.
REQ-020 number, overflow, invalid SHALL hold their values unchanged between completions, including during CONVERT.
REQ-021 load asserted on the edge ready rises is sampled in CONVERT and SHALL be ignored; a new load is accepted only on a later cycle with ready=1.
REQ-022 All-zero bcd SHALL produce number=0, overflow=0, invalid=0 after the full 4*DIGITS latency (no early exit).

Reset
REQ-023 reset=1 SHALL, on the next edge, force state IDLE, ready=1, number=0, overflow=0, invalid=0, counter=0, regardless of state or load.
REQ-024 reset SHALL abort a conversion in progress; no partial result is ever presented.
REQ-025 reset has priority over load in the same cycle.

Structure
REQ-026 Package bcd_pkg SHALL hold the state enum (IDLE, CONVERT), BCD_DIGIT_MAX=9, and ADJUST_THRESH=8 / ADJUST_SUB=3 constants, shared with the existing binary-to-BCD converter.
REQ-027 One sub-module bcd_digit_unadjust (4-bit in/out, combinational: subtract 3 if >= 8) SHALL be instantiated DIGITS times; counter width SHALL be $clog2(4*DIGITS+1).

Verification
REQ-028 reset 2 cycles, bcd=0x12345, load 1 cycle -> ready low 20 cycles, then number=12345 (0x3039), overflow=0, invalid=0.
REQ-029 bcd=0x65535 -> number=0xFFFF, overflow=0; bcd=0x65536 -> number=0xFFFF, overflow=1; bcd=0x99999 -> overflow=1.
REQ-030 bcd=0x1A345 -> invalid=1, number=0, overflow=0 after 20 cycles.
REQ-031 load 0x12345, then load 0x00007 at cycle 5 of conversion -> result 12345; subsequent load in IDLE -> 7.
REQ-032 load 0x12345, reset at cycle 10 -> next edge ready=1, number=0; fresh load 0x00042 -> number=42 after 20 cycles.
REQ-033 Back-to-back: load on cycle after ready rises -> accepted, ready drops next edge, previous number held until new completion.
